// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address from boot, trap, redirect, halt and hold requests.
// Optional trap support (external trap, misaligned-target trap, epc/trapCause) is enabled by `define PC_SEQ_TRAP_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pcCurrent,
    input  logic        stall,
    input  logic        imemReady,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    input  logic        trap,
    input  logic        halt,
    input  logic        resume,
    output logic        pcWrite,
    output logic [31:0] pcNext,
    output logic [31:0] epc,
    output logic [1:0]  trapCause,
    output logic        halted,
    output logic [31:0] fetchCount
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_EXT = 2'd1;
    localparam logic [1:0] CAUSE_MIS = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        pc_write;
    logic [31:0] pc_next;
    logic        ext_trap;
    logic        mis_trap;
    logic        hold;

`ifdef PC_SEQ_TRAP_EN
    logic jump_mis;
    logic branch_mis;

    // Any active redirect with a non-word-aligned target traps, even if a
    // lower-priority redirect would not have been taken.
    assign jump_mis   = jump & (jumpTarget[1:0] != 2'b00);
    assign branch_mis = branchTaken & (branchTarget[1:0] != 2'b00);
    assign ext_trap   = trap;
    assign mis_trap   = jump_mis | branch_mis;
`else
    logic unused_trap;

    assign unused_trap = trap;
    assign ext_trap    = 1'b0;
    assign mis_trap    = 1'b0;
`endif

    assign hold = stall | ~imemReady;

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        pc_write      = 1'b0;
        pc_next       = pcCurrent;

        unique case (state_q)
            ST_BOOT: begin
                pc_write = 1'b1;
                pc_next  = RESET_VECTOR;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (ext_trap) begin
                    pc_write = 1'b1;
                    pc_next  = TRAP_VECTOR;
                    epc_d    = pcCurrent;
                    cause_d  = CAUSE_EXT;
                end else if (mis_trap) begin
                    pc_write = 1'b1;
                    pc_next  = TRAP_VECTOR;
                    epc_d    = pcCurrent;
                    cause_d  = CAUSE_MIS;
                end else if (jump) begin
                    pc_write = 1'b1;
                    pc_next  = jumpTarget;
                end else if (branchTaken) begin
                    pc_write = 1'b1;
                    pc_next  = branchTarget;
                end else if (halt) begin
                    state_d  = ST_HALT;
                end else if (!hold) begin
                    pc_write = 1'b1;
                    pc_next  = pcCurrent + 32'd4;
                end
            end
            ST_HALT: begin
                // Resume only re-enters RUN; the first fetch happens the cycle after.
                if (ext_trap) begin
                    pc_write = 1'b1;
                    pc_next  = TRAP_VECTOR;
                    epc_d    = pcCurrent;
                    cause_d  = CAUSE_EXT;
                    state_d  = ST_RUN;
                end else if (resume) begin
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (reset) begin
            pc_write = 1'b0;
            pc_next  = RESET_VECTOR;
        end

        fetch_count_d = fetch_count_q + {31'd0, pc_write};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            epc_q         <= 32'd0;
            cause_q       <= 2'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pcWrite    = pc_write;
    assign pcNext     = pc_next;
    assign epc        = epc_q;
    assign trapCause  = cause_q;
    assign halted     = (state_q == ST_HALT);
    assign fetchCount = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Build with or without PC_SEQ_TRAP_EN; the reference model follows the same macro.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0080;
`ifdef PC_SEQ_TRAP_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcCurrent = 32'd0;
    logic        stall = 1'b0, imemReady = 1'b1;
    logic        branchTaken = 1'b0, jump = 1'b0;
    logic [31:0] branchTarget = 32'd0, jumpTarget = 32'd0;
    logic        trap = 1'b0, halt = 1'b0, resume = 1'b0;
    logic        pcWrite, halted;
    logic [31:0] pcNext, epc, fetchCount;
    logic [1:0]  trapCause;

    pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clock(clock), .reset(reset), .pcCurrent(pcCurrent), .stall(stall),
        .imemReady(imemReady), .branchTaken(branchTaken), .branchTarget(branchTarget),
        .jump(jump), .jumpTarget(jumpTarget), .trap(trap), .halt(halt), .resume(resume),
        .pcWrite(pcWrite), .pcNext(pcNext), .epc(epc), .trapCause(trapCause),
        .halted(halted), .fetchCount(fetchCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [31:0] nx;
        bit          chk_nx;
        logic        hlt;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural view of the sequencer plus the external PC register.
    typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
    mode_t       m_mode  = M_BOOT;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_epc   = 32'd0;
    logic [1:0]  m_cause = 2'd0;
    logic [31:0] m_cnt   = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pcWrite", {31'd0, pcWrite}, {31'd0, e.wr});
            if (e.chk_nx) chk("pcNext", pcNext, e.nx);
            chk("halted", {31'd0, halted}, {31'd0, e.hlt});
            chk("epc", epc, e.epc);
            chk("trapCause", {30'd0, trapCause}, {30'd0, e.cause});
            chk("fetchCount", fetchCount, e.cnt);
        end
    end

    // Called at posedge+1: drive one cycle of inputs, predict, advance the model.
    task automatic issue(input logic st, input logic rdy, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic tr, input logic hl,
                         input logic rs);
        exp_t        e;
        logic        wr;
        logic [31:0] nx;
        bit          is_hold, trap_hit;
        logic [1:0]  cz;
        stall = st; imemReady = rdy; branchTaken = br; branchTarget = bt;
        jump = jp; jumpTarget = jt; trap = tr; halt = hl; resume = rs;
        pcCurrent = m_pc;
        e.hlt = (m_mode == M_HALT); e.epc = m_epc; e.cause = m_cause; e.cnt = m_cnt;
        wr = 1'b0; nx = m_pc; is_hold = 0; trap_hit = 0; cz = 2'd0;
        case (m_mode)
            M_BOOT: begin wr = 1'b1; nx = RV; m_mode = M_RUN; end
            M_RUN: begin
                if (TEN && tr) begin trap_hit = 1; cz = 2'd1; end
                else if (TEN && ((jp && jt[1:0] != 2'b00) || (br && bt[1:0] != 2'b00))) begin
                    trap_hit = 1; cz = 2'd2;
                end
                else if (jp) begin wr = 1'b1; nx = jt; end
                else if (br) begin wr = 1'b1; nx = bt; end
                else if (hl) m_mode = M_HALT;
                else if (st || !rdy) is_hold = 1;
                else begin wr = 1'b1; nx = m_pc + 32'd4; end
            end
            default: begin
                if (TEN && tr) begin trap_hit = 1; cz = 2'd1; end
                else if (rs) m_mode = M_RUN;
            end
        endcase
        if (trap_hit) begin
            wr = 1'b1; nx = TV; m_epc = m_pc; m_cause = cz; m_mode = M_RUN;
        end
        e.wr = wr; e.nx = nx; e.chk_nx = wr || is_hold;
        exp_q.push_back(e);
        if (wr) begin
            m_pc  = nx;
            m_cnt = m_cnt + 32'd1;
        end
        @(posedge clock); #1;
    endtask

    task automatic idle();
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        exp_t e;
        reset = 1'b1;
        m_mode = M_BOOT; m_epc = 32'd0; m_cause = 2'd0; m_cnt = 32'd0;
        repeat (cycles) begin
            e.wr = 1'b0; e.nx = RV; e.chk_nx = 1; e.hlt = 1'b0;
            e.epc = 32'd0; e.cause = 2'd0; e.cnt = 32'd0;
            exp_q.push_back(e);
            @(posedge clock); #1;
        end
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        @(posedge clock); #1;
        do_reset(2);
        // Boot then sequential 0, 4, 8, 12
        repeat (4) idle();

        // Jump beats stall
        m_pc = 32'h100;
        issue(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        // Hold with imemReady low
        issue(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        // Trap beats jump
        m_pc = 32'h40;
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0);
        idle();
        // Misaligned branch target
        m_pc = 32'h60;
        issue(1'b0, 1'b1, 1'b1, 32'h102, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle();

        // Halt for 5 cycles, resume, then fetch
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (5) issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle();
        // Halt + resume together in HALT, then trap out of HALT
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        m_pc = 32'h500;
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle();

        // PC wrap and fetch counter wrap
        m_pc = 32'hFFFF_FFFC;
        idle();
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1 release dut.fetch_count_q;
        m_cnt = 32'hFFFF_FFFE;
        repeat (3) idle();

        // Reset while halted, and during a redirect
        issue(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        do_reset(1);
        repeat (2) idle();
        m_pc = 32'h700;
        jump = 1'b1; jumpTarget = 32'h900;
        do_reset(2);
        repeat (3) idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) do_reset($urandom_range(1, 2));
            if ($urandom_range(15) == 0) m_pc = $urandom() & 32'hFFFF_FFFC;
            issue($urandom_range(3) == 0, $urandom_range(3) != 0,
                  $urandom_range(5) == 0, rand_target(),
                  $urandom_range(7) == 0, rand_target(),
                  $urandom_range(15) == 0, $urandom_range(11) == 0,
                  $urandom_range(2) == 0);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0080, is the trap handler entry address.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 pcCurrent  input  32  current PC register value.
REQ-006 stall  input  1  pipeline hazard hold request.
REQ-007 imemReady  input  1  instruction memory accepts a fetch this cycle.
REQ-008 branchTaken  input  1  taken-branch redirect; target on branchTarget (input, 32).
REQ-009 jump  input  1  jump redirect; target on jumpTarget (input, 32).
REQ-010 trap  input  1  external trap request.
REQ-011 halt  input  1  halt request; resume (input, 1) releases the halt.
REQ-012 pcWrite  output  1  PC register load enable (combinational).
REQ-013 pcNext  output  32  value to load into the PC register (combinational).
REQ-014 epc  output  32  registered PC saved on trap entry.
REQ-015 trapCause  output  2  registered cause: 0 none, 1 external, 2 misaligned target.
REQ-016 halted  output  1  high while the FSM is in HALT.
REQ-017 fetchCount  output  32  registered count of cycles with pcWrite=1; wraps 32'hFFFF_FFFF->0.

Function
REQ-018 FSM states: BOOT, RUN, HALT; encoding is free.
REQ-019 BOOT: pcWrite=1, pcNext=RESET_VECTOR, next state RUN, regardless of the other inputs.
REQ-020 RUN priority: trap > misaligned redirect > jump > branchTaken > halt > hold > sequential.
REQ-021 trap in RUN or HALT: pcWrite=1, pcNext=TRAP_VECTOR, epc<=pcCurrent, trapCause<=1, next state RUN.
REQ-022 jump/branch target with bits[1:0]!=0: treated as a trap with trapCause<=2 and epc<=pcCurrent.
REQ-023 Valid jump: pcWrite=1, pcNext=jumpTarget; valid branch: pcWrite=1, pcNext=branchTarget; both apply even when stall=1 or imemReady=0.
REQ-024 halt with no redirect: pcWrite=0, next state HALT.
REQ-025 Hold (stall=1 or imemReady=0, no redirect, no halt): pcWrite=0, pcNext=pcCurrent.
REQ-026 Sequential: pcWrite=1, pcNext=pcCurrent+4, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-027 HALT: pcWrite=0; resume=1 with no trap -> RUN next cycle, no fetch in the resume cycle.
REQ-028 halt and resume both high in HALT: resume wins.
REQ-029 fetchCount increments by 1 on every rising edge where pcWrite=1.

Reset
REQ-030 Reset asserted: state=BOOT, epc=0, trapCause=0, fetchCount=0, halted=0.
REQ-031 While reset is high, pcWrite=0 and pcNext=RESET_VECTOR.
REQ-032 Reset asserted mid-operation, including in HALT or during a redirect, discards all pending activity.
REQ-033 First cycle after reset deassertion is BOOT.

Configuration
REQ-034 Macro PC_SEQ_TRAP_EN defined: trap, misaligned detection, epc and trapCause behave per REQ-021/022.
REQ-035 PC_SEQ_TRAP_EN undefined: trap input ignored, misaligned targets loaded unchanged, epc and trapCause tied 0.

Verification
REQ-036 Reset then release with RESET_VECTOR=0 -> cycle 1: pcWrite=1, pcNext=0; then pcNext=4, 8, 12 on successive cycles.
REQ-037 pcCurrent=0x100, stall=1, jump=1, jumpTarget=0x200 -> pcWrite=1, pcNext=0x200.
REQ-038 pcCurrent=0x40, trap=1, jump=1 (trap enabled) -> pcNext=0x80, epc=0x40, trapCause=1.
REQ-039 branchTarget=0x102 with branchTaken=1 -> trap enabled: pcNext=0x80, trapCause=2; trap disabled: pcNext=0x102.
REQ-040 halt=1 in RUN -> halted=1, pcWrite=0 for 5 cycles; resume=1 -> halted=0 next cycle, first fetch one cycle later.
REQ-041 pcCurrent=0xFFFF_FFFC, sequential -> pcNext=0; fetchCount preset near 0xFFFF_FFFF wraps to 0.
